// File: rtl/sr_cmd_pkg.sv
// Shared types and widths for the SR command generator.
package sr_cmd_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE_S, DRIVE_R, HOLD} state_t;

  localparam int PHASE_W = 4;
  localparam int CNT_W   = 8;
endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (inc && (count != {WIDTH{1'b1}}))
      count <= count + 1'b1;
  end
endmodule

// File: rtl/sr_command_gen.sv
// Turns set/reset requests into guarded, mutually exclusive S/R pulses for a
// downstream SR flip-flop, tracking the Q it should hold and counting conflicts.
import sr_cmd_pkg::*;

module sr_command_gen #(
  parameter int PULSE_WIDTH = 1,
  parameter int HOLD_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Set_req,
  input  logic             Reset_req,
  output logic             S,
  output logic             R,
  output logic             Q_model,
  output logic             Busy,
  output logic             Conflict,
  output logic [CNT_W-1:0] Conflict_cnt
);
  localparam logic [PHASE_W-1:0] DRIVE_LAST = PHASE_W'(PULSE_WIDTH - 1);
  localparam logic [PHASE_W-1:0] HOLD_LAST  =
    PHASE_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t               state;
  logic [PHASE_W-1:0]   phase;
  logic                 conflict_hit;

  assign conflict_hit = (state == IDLE) && Set_req && Reset_req;

  sat_counter #(.WIDTH(CNT_W)) u_conflict_cnt (
    .clk   (Clk),
    .rst_n (Rst_n),
    .inc   (conflict_hit),
    .count (Conflict_cnt)
  );

  // One phase counter times both the drive pulse and the idle guard after it.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      phase    <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      Q_model  <= 1'b0;
      Busy     <= 1'b0;
      Conflict <= 1'b0;
    end else begin
      Conflict <= 1'b0;
      case (state)
        IDLE: begin
          if (Set_req && !Reset_req) begin
            state   <= DRIVE_S;
            S       <= 1'b1;
            Q_model <= 1'b1;
            Busy    <= 1'b1;
            phase   <= DRIVE_LAST;
          end else if (Reset_req && !Set_req) begin
            state   <= DRIVE_R;
            R       <= 1'b1;
            Q_model <= 1'b0;
            Busy    <= 1'b1;
            phase   <= DRIVE_LAST;
          end else if (conflict_hit) begin
            Conflict <= 1'b1;
          end
        end
        DRIVE_S, DRIVE_R: begin
          if (phase == '0) begin
            S <= 1'b0;
            R <= 1'b0;
            if (HOLD_CYCLES == 0) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state <= HOLD;
              phase <= HOLD_LAST;
            end
          end else begin
            phase <= phase - 1'b1;
          end
        end
        HOLD: begin
          if (phase == '0) begin
            state <= IDLE;
            Busy  <= 1'b0;
          end else begin
            phase <= phase - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
